i2c_slave_rx: RTL

Open-drain I2C slave receiver/transmitter that sits directly downstream of the I2C master on the shared SDA/SCL pair. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches the 7-bit address. It ACKs matching frames, collects write bytes, and returns read bytes. Captured address/data are presented to the LED and seven-segment display logic with a one-cycle valid strobe.

---
 rtl/i2c_slave_rx_if.sv | 10 +
 rtl/i2c_slave_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx_if.sv
// Shared open-drain I2C pin bundle between the bus master and this slave.
// The slave samples scl_in/sda_in and pulls SDA low through sda_oe.
interface i2c_slave_rx_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl_in, input sda_in, output sda_oe);
  modport master (output scl_in, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C slave: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// write-byte capture with ACK and read-byte return with master ACK/NACK.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h45
) (
  input  logic        clk,
  input  logic        reset,
  i2c_slave_rx_if.slave bus,
  output logic [6:0]  rx_addr,
  output logic        rx_rw,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_req,
  output logic        busy,
  output logic        stop_seen
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WRITE, ACK_DATA, READ, MACK, IGNORE
  } state_t;

  // Synchronizers free-run through reset so no false edge appears on release.
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  always_ff @(posedge clk) begin
    scl_s1_q <= bus.scl_in;
    scl_s2_q <= scl_s1_q;
    scl_h_q  <= scl_s2_q;
    sda_s1_q <= bus.sda_in;
    sda_s2_q <= sda_s1_q;
    sda_h_q  <= sda_s2_q;
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

  always_comb begin
    scl_rise  = scl_s2_q & ~scl_h_q;
    scl_fall  = ~scl_s2_q & scl_h_q;
    sda_rise  = sda_s2_q & ~sda_h_q;
    sda_fall  = ~sda_s2_q & sda_h_q;
    start_det = sda_fall & scl_s2_q;
    stop_det  = sda_rise & scl_s2_q;
  end

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [6:0]  tx_sh_q, tx_sh_d;
  logic        mack_ok_q, mack_ok_d;
  logic        sda_oe_q, sda_oe_d;
  logic [6:0]  rx_addr_q, rx_addr_d;
  logic        rx_rw_q, rx_rw_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic        busy_q, busy_d;
  logic        stop_seen_q, stop_seen_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_sh_d     = tx_sh_q;
    mack_ok_d   = mack_ok_q;
    sda_oe_d    = sda_oe_q;
    rx_addr_d   = rx_addr_q;
    rx_rw_d     = rx_rw_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    busy_d      = busy_q;
    stop_seen_d = 1'b0;

    if (stop_det) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd7;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      stop_seen_d = 1'b1;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd7;
      shift_d   = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_s2_q};
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd7;
            if (shift_q == SLAVE_ADDR) begin
              state_d   = ACK_ADDR;
              rx_addr_d = shift_q;
              rx_rw_d   = sda_s2_q;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        // sda_oe low on entry marks the first fall (start of the ACK slot);
        // high marks the second fall (end of the slot).
        ACK_ADDR: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end else if (rx_rw_q) begin
            tx_req_d = 1'b1;
            tx_sh_d  = tx_data[6:0];
            sda_oe_d = ~tx_data[7];
            state_d  = READ;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE;
          end
        end
        WRITE: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_s2_q};
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d  = 3'd7;
            rx_data_d  = {shift_q, sda_s2_q};
            rx_valid_d = 1'b1;
            state_d    = ACK_DATA;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        ACK_DATA: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE;
          end
        end
        READ: if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
            mack_ok_d = 1'b0;
            state_d   = MACK;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            sda_oe_d  = ~tx_sh_q[6];
            tx_sh_d   = {tx_sh_q[5:0], 1'b0};
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s2_q) state_d = IGNORE;
            else          mack_ok_d = 1'b1;
          end else if (scl_fall && mack_ok_q) begin
            mack_ok_d = 1'b0;
            tx_req_d  = 1'b1;
            tx_sh_d   = tx_data[6:0];
            sda_oe_d  = ~tx_data[7];
            state_d   = READ;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      shift_q     <= '0;
      tx_sh_q     <= '0;
      mack_ok_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_addr_q   <= '0;
      rx_rw_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_sh_q     <= tx_sh_d;
      mack_ok_q   <= mack_ok_d;
      sda_oe_q    <= sda_oe_d;
      rx_addr_q   <= rx_addr_d;
      rx_rw_q     <= rx_rw_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      busy_q      <= busy_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign rx_addr    = rx_addr_q;
  assign rx_rw      = rx_rw_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_req     = tx_req_q;
  assign busy       = busy_q;
  assign stop_seen  = stop_seen_q;

endmodule
